// File: rtl/head_tail_tag_gen.sv
// Frame-delimiter tagger: turns a valid/data word stream into {head, tail, data}
// words, truncates frames at MAX_LEN and reports length/runt/trunc once per frame.
module head_tail_tag_gen #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 12,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 60
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_data_wr,
    input  logic [DATA_W-1:0] iv_data,
    output logic [DATA_W+1:0] ov_data,
    output logic              o_data_wr,
    output logic [LEN_W-1:0]  ov_frame_len,
    output logic              o_frame_len_wr,
    output logic              o_runt,
    output logic              o_trunc
);

    if (MAX_LEN < 1 || MAX_LEN >= (1 << LEN_W)) begin : g_bad_max_len
        $error("head_tail_tag_gen: MAX_LEN must be in 1 .. 2**LEN_W-1");
    end

    localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] ONE_C = LEN_W'(1);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        IDLE    = 2'd1,
        TRANS   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   stage_q;
    logic                is_tail;

    // State register; the stage register delays each word by one cycle so the
    // tail decision can look at the word that follows it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            len_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            stage_q <= iv_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SYNC: begin
                if (!i_data_wr) state_d = IDLE;
            end
            IDLE: begin
                if (i_data_wr) begin
                    state_d = TRANS;
                    cnt_d   = ONE_C;
                end
            end
            TRANS: begin
                if (!i_data_wr) begin
                    state_d = IDLE;
                end else if (cnt_q == MAX_C) begin
                    state_d = DISCARD;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            DISCARD: begin
                if (!i_data_wr) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    // Output logic: a word reaching MAX_LEN closes the frame even if more follow;
    // it only counts as truncation when another word is actually pending.
    always_comb begin
        is_tail        = (state_q == TRANS) && (!i_data_wr || cnt_q == MAX_C);
        o_data_wr      = (state_q == TRANS);
        ov_data        = '0;
        if (state_q == TRANS) begin
            ov_data = {(cnt_q == ONE_C), is_tail, stage_q};
        end
        o_frame_len_wr = is_tail;
        o_runt         = is_tail && (cnt_q < MIN_C);
        o_trunc        = is_tail && i_data_wr;
        len_d          = is_tail ? cnt_q : len_q;
        ov_frame_len   = len_d;
    end

endmodule

// File: tb/tb_head_tail_tag_gen.sv
// Scoreboard bench: two taggers (default MAX_LEN and MAX_LEN=8) share one random
// stimulus stream; a frame-level model predicts every tagged word and length pulse.
module tb_head_tail_tag_gen;

    localparam int MAXA = 1518;
    localparam int MAXB = 8;
    localparam int MINL = 60;

    typedef struct packed {
        logic [9:0]  word;
        logic [31:0] cyc;
    } wexp_t;

    typedef struct packed {
        logic [11:0] len;
        logic        runt;
        logic        trunc;
        logic [31:0] cyc;
    } fexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_wr;
    logic [7:0]  din;
    logic [9:0]  a_data, b_data;
    logic        a_wr, b_wr, a_lwr, b_lwr, a_runt, b_runt, a_trunc, b_trunc;
    logic [11:0] a_len, b_len;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    wexp_t       qw0[$], qw1[$];
    fexp_t       qf0[$], qf1[$];
    logic [11:0] last_len[2];
    logic [7:0]  fbuf[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    head_tail_tag_gen dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_wr(data_wr), .iv_data(din),
        .ov_data(a_data), .o_data_wr(a_wr), .ov_frame_len(a_len),
        .o_frame_len_wr(a_lwr), .o_runt(a_runt), .o_trunc(a_trunc)
    );

    head_tail_tag_gen #(.MAX_LEN(MAXB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_wr(data_wr), .iv_data(din),
        .ov_data(b_data), .o_data_wr(b_wr), .ov_frame_len(b_len),
        .o_frame_len_wr(b_lwr), .o_runt(b_runt), .o_trunc(b_trunc)
    );

    task automatic check(input string name, input int d, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, d, cyc, got, exp);
        end
    endtask

    task automatic mon(input int d, input logic dwr, input logic [9:0] dat,
                       input logic lwr, input logic [11:0] len, input logic runt,
                       input logic trunc);
        wexp_t w;
        fexp_t f;
        bit    empty;
        if (!rst_n) begin
            last_len[d] = '0;
            check("reset_outputs", d, {dwr, dat, lwr, len, runt, trunc}, 64'd0);
            return;
        end
        if (dwr) begin
            empty = (d == 0) ? (qw0.size() == 0) : (qw1.size() == 0);
            if (empty) begin
                check("unexpected_word", d, {22'd0, dat, cyc}, 64'd0);
            end else begin
                w = (d == 0) ? qw0.pop_front() : qw1.pop_front();
                check("word", d, {22'd0, dat, cyc}, {22'd0, w.word, w.cyc});
            end
        end else begin
            check("idle_data", d, {54'd0, dat}, 64'd0);
        end
        if (lwr) begin
            empty = (d == 0) ? (qf0.size() == 0) : (qf1.size() == 0);
            if (empty) begin
                check("unexpected_len", d, {50'd0, len, runt, trunc}, 64'd0);
            end else begin
                f = (d == 0) ? qf0.pop_front() : qf1.pop_front();
                check("len_pulse", d, {18'd0, len, runt, trunc, cyc},
                      {18'd0, f.len, f.runt, f.trunc, f.cyc});
                last_len[d] = f.len;
            end
        end else begin
            check("len_hold", d, {50'd0, len, runt, trunc}, {50'd0, last_len[d], 2'b00});
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_wr, a_data, a_lwr, a_len, a_runt, a_trunc);
        mon(1, b_wr, b_data, b_lwr, b_len, b_runt, b_trunc);
    end

    // Reference: frame of n words -> first min(n,MAX) words, head on first,
    // tail on last emitted, one length record; output one cycle after input.
    task automatic expect_word(input int i, input int n);
        int    m, nout;
        wexp_t w;
        fexp_t f;
        for (int d = 0; d < 2; d++) begin
            m    = (d == 0) ? MAXA : MAXB;
            nout = (n < m) ? n : m;
            if (i < nout) begin
                w.word = {(i == 0), (i == nout - 1), fbuf[i]};
                w.cyc  = cyc + 1;
                if (d == 0) qw0.push_back(w); else qw1.push_back(w);
            end
            if (i == nout - 1) begin
                f.len   = 12'(nout);
                f.runt  = (nout < MINL);
                f.trunc = (n > m);
                f.cyc   = cyc + 1;
                if (d == 0) qf0.push_back(f); else qf1.push_back(f);
            end
        end
    endtask

    task automatic send_frame(input int n, input int gap);
        $display("frame len=%0d gap=%0d first=%h", n, gap, fbuf[0]);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_wr = 1'b1;
            din     = fbuf[i];
            expect_word(i, n);
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            data_wr = 1'b0;
            din     = 8'($urandom);
        end
    endtask

    task automatic fill_seq(input int n, input logic [7:0] base);
        fbuf.delete();
        for (int i = 0; i < n; i++) fbuf.push_back(base + 8'(i));
    endtask

    task automatic fill_rand(input int n);
        fbuf.delete();
        for (int i = 0; i < n; i++) fbuf.push_back(8'($urandom));
    endtask

    initial begin
        rst_n   = 1'b0;
        data_wr = 1'b0;
        din     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        fbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(4, 1);
        fbuf = '{8'hA5};
        send_frame(1, 2);
        fill_seq(10, 8'h01);
        send_frame(10, 1);
        fill_seq(3, 8'h20);
        send_frame(3, 1);
        fill_seq(8, 8'h30);
        send_frame(8, 1);
        fill_seq(9, 8'h40);
        send_frame(9, 1);

        // Reset after word 3 of a 10-word frame, released while words still arrive
        $display("frame len=10 with reset mid-frame");
        fill_seq(10, 8'h61);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) rst_n = 1'b0;
            if (i == 5) rst_n = 1'b1;
            data_wr = 1'b1;
            din     = fbuf[i];
            if (i < 2) expect_word(i, 10);
        end
        @(posedge clk); #1;
        data_wr = 1'b0;
        @(posedge clk);
        fill_seq(5, 8'h80);
        send_frame(5, 1);

        fill_rand(64);
        send_frame(64, 1);
        fill_rand(64);
        send_frame(64, 1);
        fill_rand(59);
        send_frame(59, 1);
        fill_rand(60);
        send_frame(60, 2);
        fill_rand(MAXA);
        send_frame(MAXA, 1);
        fill_rand(MAXA + 2);
        send_frame(MAXA + 2, 1);

        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(1, 100);
            fill_rand(n);
            send_frame(n, $urandom_range(1, 3));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_words", 0, 64'(qw0.size()), 64'd0);
        check("pending_words", 1, 64'(qw1.size()), 64'd0);
        check("pending_lens", 0, 64'(qf0.size()), 64'd0);
        check("pending_lens", 1, 64'(qf1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
